// File: rtl/sa_ofmap_collector.sv
// sa_ofmap_collector
//   Output-side companion of the systolic array. It takes the column-skewed
//   psum stream, delay-matches the columns into aligned rows, requantises each
//   element, and buffers whole rows in a first-word fall-through FIFO. The
//   ofmap writer drains the FIFO with a valid/ready handshake.
//
//   Optional feature: define OFMAP_RELU_EN to clamp negative requantised
//   values to 0 before they enter the FIFO.
//
// Ports
//   clk             clock, rising edge
//   nrst            asynchronous active-low reset
//   load_layer_info one-cycle pulse: latch w_width/out_rows/shift, flush, arm
//   w_width         active column count (0 or > WIDTH means all columns)
//   out_rows        rows expected for the layer
//   shift           arithmetic right-shift applied to each psum
//   data_iv         marks column 0 of a skewed row
//   data_id         skewed psums, column j at [j*PSUM_WIDTH +: PSUM_WIDTH]
//   ofmap_ov        FIFO head valid
//   ofmap_od        FIFO head row, column j at [j*DATA_WIDTH +: DATA_WIDTH]
//   ofmap_ordy      consumer ready
//   busy            state is not IDLE
//   done            one-cycle pulse once the layer has drained
//   overflow        sticky: a row was dropped because the FIFO was full
module sa_ofmap_collector #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = DATA_WIDTH * 2 + $clog2(HEIGHT),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          load_layer_info,
    input  logic [3:0]                    w_width,
    input  logic [7:0]                    out_rows,
    input  logic [4:0]                    shift,
    input  logic                          data_iv,
    input  logic [WIDTH*PSUM_WIDTH-1:0]   data_id,
    output logic                          ofmap_ov,
    output logic [WIDTH*DATA_WIDTH-1:0]   ofmap_od,
    input  logic                          ofmap_ordy,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = PSUM_WIDTH'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Layer configuration
    // ------------------------------------------------------------------
    logic [4:0]       shift_cfg;
    logic [7:0]       out_rows_cfg;
    logic [WIDTH-1:0] col_en;
    logic [WIDTH-1:0] col_en_load;

    // NOTE: combinational blocks assign a default to every output first, so
    // no path through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        col_en_load = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (w_width == 4'd0 || int'(w_width) > WIDTH) col_en_load[j] = 1'b1;
            else                                          col_en_load[j] = (j < int'(w_width));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_cfg    <= '0;
            out_rows_cfg <= '0;
            col_en       <= '0;
        end else if (load_layer_info) begin
            shift_cfg    <= shift;
            out_rows_cfg <= out_rows;
            col_en       <= col_en_load;
        end
    end

    // ------------------------------------------------------------------
    // Deskew: column j waits WIDTH-1-j cycles so all columns line up with
    // the last column, which arrives WIDTH-1 cycles after column 0.
    // ------------------------------------------------------------------
    logic signed [PSUM_WIDTH-1:0] col_in      [WIDTH];
    logic signed [PSUM_WIDTH-1:0] col_aligned [WIDTH];

    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        localparam int STAGES = WIDTH - 1 - j;
        assign col_in[j] = data_id[j*PSUM_WIDTH +: PSUM_WIDTH];
        if (STAGES == 0) begin : g_pass
            assign col_aligned[j] = col_in[j];
        end else begin : g_dly
            logic signed [PSUM_WIDTH-1:0] dly [STAGES];
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int k = 0; k < STAGES; k++) dly[k] <= '0;
                end else begin
                    dly[0] <= col_in[j];
                    for (int k = 1; k < STAGES; k++) dly[k] <= dly[k-1];
                end
            end
            assign col_aligned[j] = dly[STAGES-1];
        end
    end

    // Rows are only accepted while armed or collecting.
    logic             accept_iv;
    logic [WIDTH-2:0] vld_sr;
    logic             row_vld;

    assign accept_iv = data_iv && (state == S_ARMED || state == S_COLLECT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_sr <= '0;
        end else if (load_layer_info) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= accept_iv;
            for (int k = 1; k < WIDTH - 1; k++) vld_sr[k] <= vld_sr[k-1];
        end
    end

    assign row_vld = vld_sr[WIDTH-2];

    // ------------------------------------------------------------------
    // Requantise: shift, saturate, optional ReLU, mask inactive columns
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] requant(
        input logic signed [PSUM_WIDTH-1:0] psum,
        input logic        [4:0]            sh,
        input logic                         en
    );
        logic signed [PSUM_WIDTH-1:0] shifted;
        logic signed [PSUM_WIDTH-1:0] sat;
        shifted = psum >>> sh;
        if (shifted > SAT_MAX)      sat = SAT_MAX;
        else if (shifted < SAT_MIN) sat = SAT_MIN;
        else                        sat = shifted;
`ifdef OFMAP_RELU_EN
        if (sat[PSUM_WIDTH-1]) sat = '0;
`endif
        if (!en) sat = '0;
        return sat[DATA_WIDTH-1:0];
    endfunction

    logic [WIDTH*DATA_WIDTH-1:0] req_row_d;
    logic [WIDTH*DATA_WIDTH-1:0] req_row;
    logic                        req_vld;

    always_comb begin
        req_row_d = '0;
        for (int j = 0; j < WIDTH; j++)
            req_row_d[j*DATA_WIDTH +: DATA_WIDTH] = requant(col_aligned[j], shift_cfg, col_en[j]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            req_vld <= 1'b0;
            req_row <= '0;
        end else begin
            req_vld <= row_vld && !load_layer_info;
            req_row <= req_row_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [WIDTH*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic                        push_try, push_ok, pop, full, drop;

    assign push_try = req_vld && (state == S_COLLECT);
    assign pop      = ofmap_ov && ofmap_ordy;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_try && (!full || pop);
    assign drop     = push_try && full && !pop;

    // NOTE: the storage array has no reset; the head is only visible through
    // ofmap_od when count is non-zero, and count itself is reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= req_row;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (load_layer_info) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign ofmap_ov = (count != '0);
    assign ofmap_od = ofmap_ov ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                overflow <= 1'b0;
        else if (load_layer_info) overflow <= 1'b0;
        else if (drop)            overflow <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Row counter and control FSM
    // ------------------------------------------------------------------
    logic [7:0] row_cnt;
    logic [7:0] rows_next;
    logic       last_row;

    // Dropped rows are push attempts too, so they still count toward out_rows.
    assign rows_next = row_cnt + 8'd1;
    assign last_row  = push_try && (rows_next == out_rows_cfg);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                row_cnt <= '0;
        else if (load_layer_info) row_cnt <= '0;
        else if (push_try)        row_cnt <= rows_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        if (load_layer_info) begin
            state_next = S_ARMED;
        end else begin
            case (state)
                S_IDLE:    state_next = S_IDLE;
                S_ARMED:   if (data_iv) state_next = S_COLLECT;
                S_COLLECT: if (last_row) state_next = S_DRAIN;
                S_DRAIN: begin
                    if (count == '0) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default:   state_next = S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
